hex_scan_display: RTL and testbench
===================================

Name: hex_scan_display

Overview:
- Parametrised, time-multiplexed hex driver for a common-anode seven-segment bank. Successor to the fixed 8-digit board display path in top.
- Takes a packed nibble vector plus per-digit decimal-point and blank masks, double-buffers it, and commits new data only at frame boundaries, so no digit ever shows half-updated data.
- Sits between top-level datapath logic and the HEX/DP/AN board pins.

Parameters:
- DIGITS, 8: number of digits scanned; legal range 1..16.
- SCAN_DIV, 1024: clk cycles each digit stays lit; legal minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_i  in  4*DIGITS  packed nibbles; digit k = data_i[4k+3:4k]; digit 0 is the rightmost (AN[0]).
- dp_i  in  DIGITS  decimal point on per digit, 1 = lit.
- blank_i  in  DIGITS  1 = digit k dark (AN[k] stays high for its slot).
- load_i  in  1  1-cycle strobe; captures data_i/dp_i/blank_i into the pending buffer.
- HEX  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- AN  out  DIGITS  anode enables, active-low, at most one low at any time.
- frame_o  out  1  1-cycle pulse on every scan wrap.

Behaviour:
- Reset (reset=0, async): AN all 1, HEX=7'h7F, DP=1, frame_o=0, prescaler=0, idx=0, active and pending buffers cleared, pend_v=0.
- Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 ("tick").
- On a tick, idx advances. If idx=DIGITS-1, it wraps to 0 and this is the "wrap" event.
- On a wrap: frame_o=1 for that one cycle. If pend_v=1, pending is copied to active and pend_v clears.
- load_i on a non-wrap cycle: pending <= inputs, pend_v <= 1. A later load before the wrap overwrites pending (last wins).
- load_i on the wrap cycle: inputs go straight to active, pend_v <= 0, and any older pending data is discarded.
- Outputs are registered, with one clk of lag behind idx:
  - AN <= ~(1<<idx) unless blank[idx]=1, in which case AN <= all 1.
  - HEX <= dec(active nibble idx).
  - DP <= ~dp[idx].
- Decode, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- DIGITS=1: idx is fixed at 0, every tick is a wrap, and frame_o pulses every SCAN_DIV cycles.
- Reset asserted mid-frame forces the reset values immediately. After release, scanning restarts at idx=0 with prescaler=0.
- Widths: prescaler is $clog2(SCAN_DIV) bits; idx is max(1,$clog2(DIGITS)) bits.

Optional Feature:
- Macro HEX_SCAN_DIM_EN.
- When defined:
  - Adds input dim_i[3:0].
  - Within each digit slot, AN stays all-1 unless prescaler < ((dim_i+1)*SCAN_DIV)>>4. dim_i=15 gives full brightness.
  - HEX and DP are unaffected.
  - dim_i is sampled once per slot, on the tick.
- When undefined: there is no dim_i port, and AN is on for the full slot.

Test Plan (DIGITS=8, SCAN_DIV=4 unless noted):
- Reset low for 5 cycles, then release: during reset AN=8'hFF, HEX=7'h7F, DP=1. First AN=8'hFE appears at cycle 1 after release. frame_o first pulses at cycle 31.
- load_i with data_i=32'h0123_4567, dp_i=8'h01, blank_i=0, mid-frame: the old active data shows until the wrap. Next frame: slot 0 HEX=1111000 ('7') with DP=0, slot 7 HEX=1000000 ('0').
- Two loads in one frame (32'h1111_1111 then 32'hFFFF_FFFF): next frame shows F (0001110) on all digits. No frame ever shows 1.
- load_i coincident with frame_o: the new data appears from idx 0 of the immediately following frame, and pend_v=0.
- blank_i=8'hF0: AN is never low in slots 4..7. AN sequence is FE, FD, FB, F7, FF, FF, FF, FF.
- Reset asserted at idx=5: outputs go to reset values asynchronously before the next clk edge. Active data is cleared, so the next displayed frame shows 0 on all digits.

Source files
------------

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed, double-buffered hex driver for a
// common-anode seven-segment bank. New data is committed to the displayed
// (active) buffer only at scan wrap, so a frame never mixes old and new digits.
// Optional feature: define HEX_SCAN_DIM_EN to add a dim_i[3:0] brightness input
// that shortens the lit portion of each digit slot.
module hex_scan_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  load_i,
`ifdef HEX_SCAN_DIM_EN
  input  logic [3:0]            dim_i,
`endif
  output logic [6:0]            HEX,
  output logic                  DP,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_PENULT = PW'(SCAN_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]         presc_reg;
  logic [IW-1:0]         idx_reg;
  logic [4*DIGITS-1:0]   act_data_reg, pend_data_reg;
  logic [DIGITS-1:0]     act_dp_reg, pend_dp_reg;
  logic [DIGITS-1:0]     act_blank_reg, pend_blank_reg;
  logic                  pend_v_reg;
  logic [6:0]            hex_reg;
  logic                  dp_reg;
  logic [DIGITS-1:0]     an_reg;
  logic                  frame_reg;

  logic                  tick, wrap, pre_wrap, lit;
  logic [3:0]            nib;
  logic [6:0]            hex_next;
  logic [DIGITS-1:0]     an_next;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign tick     = (presc_reg == PRE_LAST);
  assign wrap     = tick && (idx_reg == IDX_LAST);
  // One cycle ahead of wrap, so the registered frame_o lines up with wrap.
  assign pre_wrap = (presc_reg == PRE_PENULT) && (idx_reg == IDX_LAST);

`ifdef HEX_SCAN_DIM_EN
  logic [3:0]  dim_reg;
  logic [31:0] dim_thr;

  // Brightness level is held constant for a whole slot, refreshed on each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    dim_reg <= 4'hF;
    else if (tick) dim_reg <= dim_i;
  end

  assign dim_thr = ((32'(dim_reg) + 32'd1) * 32'(SCAN_DIV)) >> 4;
  assign lit     = (32'(presc_reg) < dim_thr);
`else
  assign lit = 1'b1;
`endif

  // Prescaler and digit index: idx advances once per SCAN_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick) idx_reg <= wrap ? '0 : idx_reg + 1'b1;
    end
  end

  // Double buffer: loads park in pending, commit at wrap; a load on the wrap
  // cycle itself goes straight to active and drops any older pending data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_data_reg   <= '0;
      act_dp_reg     <= '0;
      act_blank_reg  <= '0;
      pend_data_reg  <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '0;
      pend_v_reg     <= 1'b0;
    end else if (wrap) begin
      if (load_i) begin
        act_data_reg  <= data_i;
        act_dp_reg    <= dp_i;
        act_blank_reg <= blank_i;
      end else if (pend_v_reg) begin
        act_data_reg  <= pend_data_reg;
        act_dp_reg    <= pend_dp_reg;
        act_blank_reg <= pend_blank_reg;
      end
      pend_v_reg <= 1'b0;
    end else if (load_i) begin
      pend_data_reg  <= data_i;
      pend_dp_reg    <= dp_i;
      pend_blank_reg <= blank_i;
      pend_v_reg     <= 1'b1;
    end
  end

  // Segment pattern for the digit currently being scanned.
  always_comb begin
    nib      = act_data_reg[{idx_reg, 2'b00} +: 4];
    hex_next = seg_decode(nib);
  end

  // One anode per digit: low only in its own slot, when not blanked and lit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_an
      assign an_next[gi] = ~(lit && (idx_reg == IW'(gi)) && !act_blank_reg[gi]);
    end
  endgenerate

  // Registered pin drivers, one clk behind idx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_reg    <= '1;
      hex_reg   <= 7'h7F;
      dp_reg    <= 1'b1;
      frame_reg <= 1'b0;
    end else begin
      an_reg    <= an_next;
      hex_reg   <= hex_next;
      dp_reg    <= ~act_dp_reg[idx_reg];
      frame_reg <= pre_wrap;
    end
  end

  assign AN      = an_reg;
  assign HEX     = hex_reg;
  assign DP      = dp_reg;
  assign frame_o = frame_reg;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display (DIGITS=8, SCAN_DIV=4): a cycle-count based model
// plus directed checks with hand-computed segment/anode values.
module tb_hex_scan_display;

  localparam int ND    = 8;
  localparam int SD    = 4;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   data_i = '0;
  logic [7:0]    dp_i = '0;
  logic [7:0]    blank_i = '0;
  logic          load_i = 1'b0;
  logic [6:0]    HEX;
  logic          DP;
  logic [7:0]    AN;
  logic          frame_o;

  hex_scan_display #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i),
    .load_i(load_i), .HEX(HEX), .DP(DP), .AN(AN), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Segment table written straight from the digit shapes.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  // Model: position in the scan is pure arithmetic on cycles since reset.
  function automatic int slot_of(input int tt);
    return (tt / SD) % ND;
  endfunction

  int          t;
  logic [31:0] m_data, m_pdata;
  logic [7:0]  m_dp, m_pdp, m_blank, m_pblank;
  logic        m_pv;
  logic [7:0]  exp_an;
  logic [6:0]  exp_hex;
  logic        exp_dp, exp_frame;

  // Model update: outputs for the next cycle, then frame-boundary buffering.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t <= 0;
      m_data <= '0; m_dp <= '0; m_blank <= '0;
      m_pdata <= '0; m_pdp <= '0; m_pblank <= '0; m_pv <= 1'b0;
      exp_an <= 8'hFF; exp_hex <= 7'h7F; exp_dp <= 1'b1; exp_frame <= 1'b0;
    end else begin
      exp_an    <= m_blank[slot_of(t)] ? 8'hFF : ~(8'd1 << slot_of(t));
      exp_hex   <= seg_tab[m_data[4*slot_of(t) +: 4]];
      exp_dp    <= ~m_dp[slot_of(t)];
      exp_frame <= (((t + 1) % FRAME) == FRAME - 1);
      if ((t % FRAME) == FRAME - 1) begin
        if (load_i) begin
          m_data <= data_i; m_dp <= dp_i; m_blank <= blank_i;
        end else if (m_pv) begin
          m_data <= m_pdata; m_dp <= m_pdp; m_blank <= m_pblank;
        end
        m_pv <= 1'b0;
      end else if (load_i) begin
        m_pdata <= data_i; m_pdp <= dp_i; m_pblank <= blank_i; m_pv <= 1'b1;
      end
      t <= t + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_an", AN, exp_an);
      check("model_hex", HEX, exp_hex);
      check("model_dp", DP, exp_dp);
      check("model_frame", frame_o, exp_frame);
      check("an_at_most_one_low", ($countones(~AN) <= 1), 1);
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    data_i = d; dp_i = dp; blank_i = bl; load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_an", AN, 8'hFF);
      check("rst_hex", HEX, 7'h7F);
      check("rst_dp", DP, 1'b1);
    end
    #2 reset = 1'b1;
    cyc = 0;

    step();
    check("first_an", AN, 8'hFE);
    goto(30);
    check("frame_not_yet", frame_o, 1'b0);
    goto(31);
    check("first_frame", frame_o, 1'b1);

    // Mid-frame load: old data until the wrap.
    goto(40);
    load(32'h0123_4567, 8'h01, 8'h00);
    goto(50);
    check("old_data_shown", HEX, 7'b1000000);
    goto(65);
    check("slot0_hex_7", HEX, 7'b1111000);
    check("slot0_dp_on", DP, 1'b0);
    check("slot0_an", AN, 8'hFE);
    goto(93);
    check("slot7_hex_0", HEX, 7'b1000000);
    check("slot7_an", AN, 8'h7F);
    check("slot7_dp_off", DP, 1'b1);

    // Two loads in one frame: last wins.
    goto(100);
    load(32'h1111_1111, 8'h00, 8'h00);
    goto(110);
    load(32'hFFFF_FFFF, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      goto(129 + 4 * i);
      check("all_f", HEX, 7'b0001110);
    end
    // Pending load that the wrap-cycle load must discard.
    goto(150);
    load(32'h5555_5555, 8'h00, 8'h00);
    for (int i = 6; i < 8; i++) begin
      goto(129 + 4 * i);
      check("all_f", HEX, 7'b0001110);
    end

    // Load coincident with frame_o.
    goto(159);
    check("frame_at_wrap_load", frame_o, 1'b1);
    load(32'h89AB_CDE2, 8'h80, 8'h00);
    goto(161);
    check("wrap_load_slot0", HEX, 7'b0100100);
    check("wrap_load_dp0", DP, 1'b1);
    goto(189);
    check("wrap_load_slot7", HEX, 7'b0000000);
    check("wrap_load_dp7", DP, 1'b0);
    goto(193);
    check("pending_discarded", HEX, 7'b0100100);

    // Blank upper four digits.
    goto(200);
    load(32'h0123_4567, 8'h00, 8'hF0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] an_req;
      an_req = (i < 4) ? ~(8'd1 << i) : 8'hFF;
      goto(225 + 4 * i);
      check("blank_an_seq", AN, an_req);
    end

    // Reset during idx 5: asynchronous effect, active cleared afterwards.
    goto(278);
    #2 reset = 1'b0;
    #1;
    check("async_rst_an", AN, 8'hFF);
    check("async_rst_hex", HEX, 7'h7F);
    check("async_rst_dp", DP, 1'b1);
    check("async_rst_frame", frame_o, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] an_req;
      an_req = ~(8'd1 << i);
      goto(1 + 4 * i);
      check("post_rst_hex0", HEX, 7'b1000000);
      check("post_rst_an", AN, an_req);
    end
    goto(31);
    check("post_rst_frame", frame_o, 1'b1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
